// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with word-serial line refill and a cache_en bypass path.
// Optional hit/miss statistics counters are enabled by defining INST_CACHE_STATS_EN.
module inst_cache #(
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 16
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        cache_en,
   input  logic [31:0] pc,
   input  logic        flush,
   output logic [31:0] inst,
   output logic        hit,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
`ifdef INST_CACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int OB = $clog2(LINE_WORDS);
   localparam int IB = $clog2(NUM_LINES);
   localparam int TW = 30 - OB - IB;
   localparam int LW = 30 - OB;
   localparam logic [OB-1:0] LAST_WORD = OB'(LINE_WORDS - 1);

   typedef enum logic {IDLE, REFILL} state_t;

   state_t          state_q, state_d;
   logic [OB-1:0]   cnt_q, cnt_d;
   logic [LW-1:0]   line_q, line_d;
   logic            mem_req_q, mem_req_d;
   logic [31:0]     mem_addr_q, mem_addr_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [TW-1:0]   tag_q  [NUM_LINES];
   logic [31:0]     data_q [NUM_LINES*LINE_WORDS];
   logic            data_we, tag_we;

   logic [OB-1:0]   offset;
   logic [IB-1:0]   index;
   logic [TW-1:0]   tag;
   logic [IB-1:0]   refill_index;
   logic            lookup_hit;
   logic            pc_unused;

   assign offset       = pc[OB+1:2];
   assign index        = pc[OB+IB+1:OB+2];
   assign tag          = pc[31:OB+IB+2];
   assign refill_index = line_q[IB-1:0];
   assign pc_unused    = ^pc[1:0];

   assign lookup_hit = cache_en && (state_q == IDLE) && valid_q[index] && (tag_q[index] == tag);

   // Everything the fetch stage and memory see is forced quiet while reset is held.
   assign hit      = rst_b && lookup_hit;
   assign mem_req  = rst_b && (!cache_en || mem_req_q);
   assign mem_addr = !rst_b ? 32'd0 : (cache_en ? mem_addr_q : {pc[31:2], 2'b00});
   assign inst     = !rst_b ? 32'd0 :
                     !cache_en ? mem_rdata :
                     lookup_hit ? data_q[{index, offset}] : 32'd0;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      line_d     = line_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      valid_d    = valid_q;
      data_we    = 1'b0;
      tag_we     = 1'b0;
      case (state_q)
         IDLE: begin
            if (flush) begin
               valid_d = '0;
            end else if (cache_en && !lookup_hit) begin
               state_d        = REFILL;
               line_d         = pc[31:OB+2];
               cnt_d          = '0;
               valid_d[index] = 1'b0;
               mem_req_d      = 1'b1;
               mem_addr_d     = {pc[31:OB+2], {(OB+2){1'b0}}};
            end
         end
         REFILL: begin
            // Flush beats a completing refill, so the line is never marked valid here.
            if (flush) begin
               valid_d   = '0;
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end else if (!cache_en) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end else if (mem_rvalid) begin
               data_we    = 1'b1;
               cnt_d      = cnt_q + 1'b1;
               mem_addr_d = mem_addr_q + 32'd4;
               if (cnt_q == LAST_WORD) begin
                  state_d               = IDLE;
                  mem_req_d             = 1'b0;
                  valid_d[refill_index] = 1'b1;
                  tag_we                = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         line_q     <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= 32'd0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         line_q     <= line_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         valid_q    <= valid_d;
      end
   end

   // Data and tag storage need no reset; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (data_we) data_q[{refill_index, cnt_q}] <= mem_rdata;
      if (tag_we)  tag_q[refill_index] <= line_q[LW-1:IB];
   end

`ifdef INST_CACHE_STATS_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   always_comb begin
      hit_count_d  = hit_count_q + {31'd0, lookup_hit};
      miss_count_d = miss_count_q + {31'd0, (state_q == IDLE) && (state_d == REFILL)};
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         hit_count_q  <= 32'd0;
         miss_count_q <= 32'd0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Randomized scoreboard bench for inst_cache: a line-level cache model predicts every cycle's outputs.
// Memory contents are a fixed hash of the word address so any returned word can be predicted.
module tb_inst_cache;

   localparam int LW = 4;
   localparam int NL = 16;
   localparam int CYCLES = 3000;

   function automatic logic [31:0] memfun(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
   endfunction

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        cache_en = 1'b1;
   logic        flush = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] pc = 32'd0;
   logic [31:0] inst, mem_addr, mem_rdata;
   logic        hit, mem_req;
`ifdef INST_CACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   always #5 clk = ~clk;

   assign mem_rdata = memfun(mem_addr);

   inst_cache #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .cache_en   (cache_en),
      .pc         (pc),
      .flush      (flush),
      .inst       (inst),
      .hit        (hit),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
`ifdef INST_CACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   typedef struct {
      logic        hit;
      logic [31:0] inst;
      logic        req;
      logic [31:0] addr;
      logic [31:0] hc;
      logic [31:0] mc;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;
   int pushed = 0;
   int popped = 0;

   // Line-level model: which line address each index currently holds, plus refill progress.
   bit          m_busy;
   logic [27:0] m_line;
   int          m_got;
   bit          m_valid [NL];
   logic [27:0] m_holds [NL];
   logic [31:0] m_hc, m_mc;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_busy = 0;
      m_got = 0;
      m_hc = 0;
      m_mc = 0;
      for (int k = 0; k < NL; k++) m_valid[k] = 0;
   endtask

   task automatic modelExpect(output exp_t e);
      int idx;
      idx = int'(pc[7:4]);
      e.hc = m_hc;
      e.mc = m_mc;
      e.addr = 32'd0;
      e.hit = 1'b0;
      e.inst = 32'd0;
      e.req = 1'b0;
      if (!cache_en) begin
         e.req = 1'b1;
         e.addr = {pc[31:2], 2'b00};
         e.inst = memfun(e.addr);
      end else if (m_busy) begin
         e.req = 1'b1;
         e.addr = {m_line, 4'h0} + 32'(4 * m_got);
      end else begin
         e.hit = m_valid[idx] && (m_holds[idx] == pc[31:4]);
         e.inst = e.hit ? memfun({pc[31:2], 2'b00}) : 32'd0;
      end
   endtask

   task automatic modelAdvance(input exp_t e);
      int idx;
      idx = int'(pc[7:4]);
      if (e.hit) m_hc++;
      if (flush) begin
         for (int k = 0; k < NL; k++) m_valid[k] = 0;
         m_busy = 0;
      end else if (!cache_en) begin
         m_busy = 0;
      end else if (m_busy) begin
         if (mem_rvalid) begin
            m_got++;
            if (m_got == LW) begin
               m_busy = 0;
               m_valid[int'(m_line[3:0])] = 1;
               m_holds[int'(m_line[3:0])] = m_line;
            end
         end
      end else if (!e.hit) begin
         m_busy = 1;
         m_line = pc[31:4];
         m_got = 0;
         m_valid[idx] = 0;
         m_mc++;
      end
   endtask

   function automatic logic [31:0] randomPc();
      logic [23:0] t;
      case ($urandom_range(0, 3))
         0: t = 24'h000000;
         1: t = 24'h000001;
         2: t = 24'h000002;
         default: t = 24'hFFFFFF;
      endcase
      return {t, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
   endfunction

   task automatic applyStimulus(input int cyc);
      exp_t e;
      if (cyc < 24) begin
         pc = (cyc < 8) ? 32'h0 : (cyc < 12) ? 32'h8 : 32'h100;
         cache_en = 1'b1;
         flush = 1'b0;
      end else begin
         if ($urandom_range(0, 99) < 15) pc = randomPc();
         cache_en = ($urandom_range(0, 99) >= 4);
         flush = ($urandom_range(0, 99) < 2);
      end
      #1;
      mem_rvalid = mem_req && ((cyc < 24) || ($urandom_range(0, 99) < 55));
      modelExpect(e);
      sb.push_back(e);
      pushed++;
      modelAdvance(e);
   endtask

   task automatic checkOutput(input exp_t e);
      check32("hit", {31'd0, hit}, {31'd0, e.hit});
      check32("inst", inst, e.inst);
      check32("mem_req", {31'd0, mem_req}, {31'd0, e.req});
      if (e.req) check32("mem_addr", mem_addr, e.addr);
`ifdef INST_CACHE_STATS_EN
      check32("hit_count", hit_count, e.hc);
      check32("miss_count", miss_count, e.mc);
`endif
   endtask

   // Monitor: compares whatever the DUT presents against the oldest prediction.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            checkOutput(sb.pop_front());
            popped++;
         end
      end
   end

   initial begin
      bit did_rst;
      did_rst = 0;
      modelReset();
      cache_en = 1'b0;
      pc = 32'h20;
      #1;
      check32("reset_mem_req", {31'd0, mem_req}, 32'd0);
      check32("reset_hit", {31'd0, hit}, 32'd0);
      check32("reset_inst", inst, 32'd0);
      check32("reset_mem_addr", mem_addr, 32'd0);
      cache_en = 1'b1;
      pc = 32'h0;
      repeat (3) @(negedge clk);
      rst_b = 1'b1;
      for (int i = 0; i < CYCLES; i++) begin
         if (i > 0) @(negedge clk);
         if (!did_rst && i >= 1500 && (m_busy || i >= 2500)) begin
            did_rst = 1;
            rst_b = 1'b0;
            #1;
            check32("midreset_mem_req", {31'd0, mem_req}, 32'd0);
            check32("midreset_hit", {31'd0, hit}, 32'd0);
`ifdef INST_CACHE_STATS_EN
            check32("midreset_hit_count", hit_count, 32'd0);
            check32("midreset_miss_count", miss_count, 32'd0);
`endif
            @(negedge clk);
            rst_b = 1'b1;
            modelReset();
         end
         applyStimulus(i);
      end
      @(negedge clk);
      #4;
      check32("scoreboard_drained", popped, pushed);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
